// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - sample-phase counter and shared-comb sequencer for the multi-mic CIC decimator
module cic_decim_ctrl #(
  parameter int R   = 16,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                 lr_clock,
  input  logic                 i_reset,
  input  logic                 i_en,
  output logic                 o_dec_stb,
  output logic [CHW-1:0]       o_comb_sel,
  output logic                 o_comb_en,
  output logic                 o_valid,
  output logic [CHW-1:0]       o_chan,
  input  logic                 i_ready,
  output logic [$clog2(R)-1:0] o_phase,
  output logic                 o_overrun,
  input  logic                 i_clr_ovr
);

  localparam int             PW      = $clog2(R);
  localparam logic [PW-1:0]  PH_LAST = PW'(R - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, COMB, OUT} state_t;

  state_t         state, state_nxt;
  logic [CHW-1:0] ch, ch_nxt;
  logic           ev, ev_acc;
  logic           dec_stb_nxt, comb_en_nxt, valid_nxt;
  logic [CHW-1:0] sel_nxt, chan_nxt;

  // A new event may also be taken on the very cycle the last channel is handed off.
  assign ev     = i_en & (o_phase == PH_LAST);
  assign ev_acc = ev & ((state == IDLE) |
                        ((state == OUT) & i_ready & (ch == CH_LAST)));

  always_ff @(posedge lr_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_phase <= '0;
    end else if (i_en) begin
      o_phase <= (o_phase == PH_LAST) ? '0 : o_phase + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    dec_stb_nxt = 1'b0;
    comb_en_nxt = 1'b0;
    valid_nxt   = 1'b0;
    sel_nxt     = o_comb_sel;
    chan_nxt    = o_chan;
    case (state)
      IDLE: begin
        if (ev_acc) begin
          state_nxt = COMB;
          ch_nxt    = '0;
        end
      end
      COMB: state_nxt = OUT;
      OUT: begin
        if (i_ready) begin
          if (ch != CH_LAST) begin
            state_nxt = COMB;
            ch_nxt    = ch + 1'b1;
          end else if (ev_acc) begin
            state_nxt = COMB;
            ch_nxt    = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are decoded from the next state so they can be registered.
    case (state_nxt)
      COMB: begin
        comb_en_nxt = 1'b1;
        sel_nxt     = ch_nxt;
        dec_stb_nxt = ev_acc;
      end
      OUT: begin
        valid_nxt = 1'b1;
        chan_nxt  = ch_nxt;
        sel_nxt   = ch_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lr_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      ch         <= '0;
      o_dec_stb  <= 1'b0;
      o_comb_en  <= 1'b0;
      o_comb_sel <= '0;
      o_valid    <= 1'b0;
      o_chan     <= '0;
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      o_dec_stb  <= dec_stb_nxt;
      o_comb_en  <= comb_en_nxt;
      o_comb_sel <= sel_nxt;
      o_valid    <= valid_nxt;
      o_chan     <= chan_nxt;
    end
  end

  // A dropped event outranks a same-cycle clear.
  always_ff @(posedge lr_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_overrun <= 1'b0;
    end else if (ev & ~ev_acc) begin
      o_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - directed bench for cic_decim_ctrl at three parameter points
module tb_cic_decim_ctrl;

  logic clk = 1'b0;
  logic rst_n, en, rdy, clr;
  int   total = 0;
  int   bad   = 0;

  logic       a_stb, a_cen, a_vld, a_ovr;
  logic [1:0] a_sel, a_chan;
  logic [3:0] a_ph;
  logic       b_stb, b_cen, b_vld, b_ovr;
  logic [1:0] b_sel, b_chan;
  logic [2:0] b_ph;
  logic       c_stb, c_cen, c_vld, c_ovr;
  logic [0:0] c_sel, c_chan;
  logic [0:0] c_ph;

  always #5 clk = ~clk;

  cic_decim_ctrl #(.R(16), .NCH(4), .CHW(2)) dut16 (
    .lr_clock(clk), .i_reset(rst_n), .i_en(en), .o_dec_stb(a_stb), .o_comb_sel(a_sel),
    .o_comb_en(a_cen), .o_valid(a_vld), .o_chan(a_chan), .i_ready(rdy), .o_phase(a_ph),
    .o_overrun(a_ovr), .i_clr_ovr(clr));

  cic_decim_ctrl #(.R(8), .NCH(4), .CHW(2)) dut8 (
    .lr_clock(clk), .i_reset(rst_n), .i_en(en), .o_dec_stb(b_stb), .o_comb_sel(b_sel),
    .o_comb_en(b_cen), .o_valid(b_vld), .o_chan(b_chan), .i_ready(rdy), .o_phase(b_ph),
    .o_overrun(b_ovr), .i_clr_ovr(clr));

  cic_decim_ctrl #(.R(2), .NCH(1), .CHW(1)) dut2 (
    .lr_clock(clk), .i_reset(rst_n), .i_en(en), .o_dec_stb(c_stb), .o_comb_sel(c_sel),
    .o_comb_en(c_cen), .o_valid(c_vld), .o_chan(c_chan), .i_ready(rdy), .o_phase(c_ph),
    .o_overrun(c_ovr), .i_clr_ovr(clr));

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle %0d: got %0h want %0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, "_stb"}, 0, 32'(a_stb), 32'd0);
    chk({tag, "_cen"}, 0, 32'(a_cen), 32'd0);
    chk({tag, "_sel"}, 0, 32'(a_sel), 32'd0);
    chk({tag, "_vld"}, 0, 32'(a_vld), 32'd0);
    chk({tag, "_chan"}, 0, 32'(a_chan), 32'd0);
    chk({tag, "_ph"}, 0, 32'(a_ph), 32'd0);
    chk({tag, "_ovr"}, 0, 32'(a_ovr), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; clr = 1'b0;
    repeat (2) tick();
    chk_zero16("rst0");

    // continuous samples, no backpressure: one 8-cycle sequence every 16 cycles
    rst_n = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int c = 0; c <= 49; c++) begin
      int m;
      bit seq;
      if (c > 0) tick();
      m = c % 16;
      seq = (c >= 16) && (m < 8);
      chk("t2_ph", c, 32'(a_ph), 32'(m));
      chk("t2_stb", c, 32'(a_stb), 32'(seq && m == 0));
      chk("t2_cen", c, 32'(a_cen), 32'(seq && m % 2 == 0));
      chk("t2_vld", c, 32'(a_vld), 32'(seq && m % 2 == 1));
      if (seq) chk("t2_sel", c, 32'(a_sel), 32'(m / 2));
      if (seq && m % 2 == 1) chk("t2_chan", c, 32'(a_chan), 32'(m / 2));
      chk("t2_ovr", c, 32'(a_ovr), 32'd0);
    end

    // cycle 49 is OUT for ch0: reset must clear everything without a clock edge
    rst_n = 1'b0;
    #1;
    chk_zero16("t1_async");
    tick();
    chk_zero16("t1_held");

    // samples on alternate cycles: phase holds on idle cycles, events every 32
    rst_n = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      if (c > 0) tick();
      en = (c % 2 == 0);
      chk("t3_ph", c, 32'(a_ph), 32'(((c + 1) / 2) % 16));
      chk("t3_stb", c, 32'(a_stb), 32'(c % 32 == 31));
      chk("t3_ovr", c, 32'(a_ovr), 32'd0);
    end

    // stall after ch1 becomes valid; the event at cycle 31 is dropped
    en = 1'b1; rdy = 1'b1;
    restart();
    for (int c = 0; c <= 52; c++) begin
      if (c > 0) tick();
      rdy = !(c >= 19 && c <= 38);
      clr = (c == 50);
      chk("t4_ph", c, 32'(a_ph), 32'(c % 16));
      chk("t4_stb", c, 32'(a_stb), 32'(c == 16 || c == 48));
      chk("t4_cen", c, 32'(a_cen), 32'(c inside {16, 18, 40, 42, 48, 50, 52}));
      chk("t4_ovr", c, 32'(a_ovr), 32'(c >= 32 && c <= 50));
      if (c >= 19 && c <= 39) begin
        chk("t4_vld", c, 32'(a_vld), 32'd1);
        chk("t4_chan", c, 32'(a_chan), 32'd1);
      end
      if (c == 40) chk("t4_sel2", c, 32'(a_sel), 32'd2);
      if (c == 41) chk("t4_chan2", c, 32'(a_chan), 32'd2);
      if (c == 43) chk("t4_chan3", c, 32'(a_chan), 32'd3);
      if (c == 44) chk("t4_idle", c, 32'(a_vld), 32'd0);
    end
    clr = 1'b0;

    // R=8 and R=2/NCH=1: last hand-off coincides with the next event every time
    restart();
    for (int c = 0; c <= 40; c++) begin
      bit cen8, vld8;
      if (c > 0) tick();
      cen8 = (c >= 8) && (c % 2 == 0);
      vld8 = (c >= 9) && (c % 2 == 1);
      chk("t5_ph", c, 32'(b_ph), 32'(c % 8));
      chk("t5_stb", c, 32'(b_stb), 32'(c >= 8 && c % 8 == 0));
      chk("t5_cen", c, 32'(b_cen), 32'(cen8));
      chk("t5_vld", c, 32'(b_vld), 32'(vld8));
      if (cen8) chk("t5_sel", c, 32'(b_sel), 32'((c % 8) / 2));
      if (vld8) chk("t5_chan", c, 32'(b_chan), 32'(((c - 1) % 8) / 2));
      chk("t5_ovr", c, 32'(b_ovr), 32'd0);
      chk("t6_ph", c, 32'(c_ph), 32'(c % 2));
      chk("t6_stb", c, 32'(c_stb), 32'(c >= 2 && c % 2 == 0));
      chk("t6_cen", c, 32'(c_cen), 32'(c >= 2 && c % 2 == 0));
      chk("t6_vld", c, 32'(c_vld), 32'(c >= 3 && c % 2 == 1));
      chk("t6_chan", c, 32'(c_chan), 32'd0);
      chk("t6_sel", c, 32'(c_sel), 32'd0);
      chk("t6_ovr", c, 32'(c_ovr), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
